// File: rtl/sd_dac_mc.sv
// sd_dac_mc: multi-channel first-order sigma-delta DAC sharing one frame counter and one sample-set handshake.
// Optional LFSR dither is built in when the macro SD_DAC_DITHER_EN is defined.

module sd_dac_mc_channel #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load_shadow,
    input  logic          load_active,
    input  logic [DW-1:0] sample,
    input  logic          dither,
    output logic          out
);

    localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

    logic [DW-1:0] shadow;
    logic [DW-1:0] active;
    logic [DW-1:0] acc;
    logic [DW:0]   sum;

    // The carry out of the accumulator is the density bit; the remainder is kept.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, active} + {{DW{1'b0}}, dither};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            acc    <= MID;
            out    <= 1'b0;
        end else begin
            if (load_shadow) begin
                shadow <= sample;
            end
            if (load_active) begin
                active <= shadow;
            end
            if (!en) begin
                acc <= MID;
                out <= 1'b0;
            end else begin
                acc <= sum[DW-1:0];
                out <= sum[DW];
            end
        end
    end

endmodule

module sd_dac_mc #(
    parameter int DW  = 12,
    parameter int NCH = 4,
    parameter int OSR = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*DW-1:0] in_data,
    input  logic              underrun_clr,
    output logic [NCH-1:0]    out,
    output logic              frame_tick,
    output logic              underrun
);

    localparam int            CW   = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [CW-1:0] LAST = CW'(OSR - 1);

    logic [CW-1:0]  count;
    logic           pending;
    logic           boundary;
    logic           accept;
    logic           load_active;
    logic [NCH-1:0] dither;

    always_comb begin
        boundary    = en && (count == LAST);
        accept      = in_valid && !pending;
        load_active = boundary && pending;
        in_ready    = !pending;
    end

    // Frame counter only runs while enabled and restarts at the boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (!en || boundary) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    // A boundary consumes the pending set; in_ready is low during that cycle, so no accept can collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (load_active) begin
                pending <= 1'b0;
            end else if (accept) begin
                pending <= 1'b1;
            end
            if (boundary && !pending) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

`ifdef SD_DAC_DITHER_EN
    logic [15:0] lfsr;
    logic        feedback;

    always_comb begin
        feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (en) begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

    always_comb begin
        dither = '0;
        for (int k = 0; k < NCH; k++) begin
            dither[k] = lfsr[k % 16];
        end
    end
`else
    always_comb begin
        dither = '0;
    end
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        sd_dac_mc_channel #(
            .DW(DW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .load_shadow(accept),
            .load_active(load_active),
            .sample     (in_data[k*DW +: DW]),
            .dither     (dither[k]),
            .out        (out[k])
        );
    end

endmodule
